// File: rtl/bep_pkg.sv
// Shared definitions for the BEP frame controller: FSM state encoding,
// error cause codes and default framing constants.
package bep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_OVF     = 3'd4;
    localparam logic [2:0] ERR_RESTART = 3'd5;

    localparam logic [7:0] DEFAULT_SYNC    = 8'hA5;
    localparam int         DEFAULT_MAX_LEN = 16;
    localparam int         DEFAULT_TIMEOUT = 40;

    // MSB-first shift of one decoded bit into a byte
    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
        return {sr[6:0], b};
    endfunction

endpackage

// File: rtl/bep_frame_controller_if.sv
// Bundle of decoder-side bit inputs and consumer-side byte/status outputs.
// The slave modport is the controller view; master is the environment view.
interface bep_frame_controller_if;
    logic       bit_valid;
    logic       bit_data;
    logic       transmission_begin;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_done;
    logic       frame_error;
    logic [2:0] error_code;
    logic       decoder_rearm;
    logic       busy;

    modport master (
        output bit_valid, bit_data, transmission_begin, byte_ready,
        input  byte_data, byte_valid, frame_done, frame_error,
               error_code, decoder_rearm, busy
    );

    modport slave (
        input  bit_valid, bit_data, transmission_begin, byte_ready,
        output byte_data, byte_valid, frame_done, frame_error,
               error_code, decoder_rearm, busy
    );
endinterface

// File: rtl/bep_byte_assembler.sv
// Collects MSB-first decoded bits into bytes; flags the 8th bit of a byte and
// a sync match on the updated shift value. clear_i wins over a same-cycle bit.
module bep_byte_assembler
    import bep_pkg::*;
#(
    parameter logic [7:0] SYNC = DEFAULT_SYNC
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear_i,
    input  logic       bit_valid_i,
    input  logic       bit_data_i,
    output logic [7:0] byte_o,
    output logic       byte_complete_o,
    output logic       sync_match_o
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;

    // byte_o is the value the shift register takes if this bit is accepted
    assign byte_o          = shift_in(shift_q, bit_data_i);
    assign byte_complete_o = bit_valid_i && (cnt_q == 3'd7);
    assign sync_match_o    = bit_valid_i && (byte_o == SYNC);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = 8'h00;
            cnt_d   = 3'd0;
        end else if (bit_valid_i) begin
            shift_d = byte_o;
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/bep_frame_controller.sv
// Frame sequencer: hunts SYNC, reads a length byte, streams payload bytes over
// valid/ready and verifies an XOR checksum covering length and payload.
module bep_frame_controller
    import bep_pkg::*;
#(
    parameter logic [7:0] SYNC    = DEFAULT_SYNC,
    parameter int         MAX_LEN = DEFAULT_MAX_LEN,
    parameter int         TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bep_frame_controller_if.slave bus
);

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_T = TW'(TIMEOUT);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    checksum_q, checksum_d;
    logic [4:0]    remaining_q, remaining_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_error_q, frame_error_d;
    logic          rearm_q, rearm_d;
    logic [2:0]    error_code_q, error_code_d;

    logic          asm_clear;
    logic [7:0]    asm_byte;
    logic          asm_complete;
    logic          asm_sync;
    logic          timed_out;

    bep_byte_assembler #(.SYNC(SYNC)) u_asm (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear_i         (asm_clear),
        .bit_valid_i     (bus.bit_valid),
        .bit_data_i      (bus.bit_data),
        .byte_o          (asm_byte),
        .byte_complete_o (asm_complete),
        .sync_match_o    (asm_sync)
    );

    assign timed_out = !bus.bit_valid && (timer_q == TIMEOUT_T);

    always_comb begin
        state_d       = state_q;
        asm_clear     = 1'b0;
        checksum_d    = checksum_q;
        remaining_d   = remaining_q;
        byte_data_d   = byte_data_q;
        byte_valid_d  = byte_valid_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        rearm_d       = 1'b0;
        error_code_d  = error_code_q;

        if (bus.bit_valid)
            timer_d = '0;
        else if (timer_q != TIMEOUT_T)
            timer_d = timer_q + TW'(1);
        else
            timer_d = timer_q;

        // A handshake may drain the byte in any state; a same-cycle load below overrides it
        if (byte_valid_q && bus.byte_ready)
            byte_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                asm_clear = 1'b1;
                timer_d   = '0;
                if (bus.transmission_begin)
                    state_d = ST_HUNT;
            end

            ST_HUNT: begin
                if (bus.transmission_begin) begin
                    asm_clear = 1'b1;
                    timer_d   = '0;
                end else if (asm_sync) begin
                    asm_clear = 1'b1;
                    state_d   = ST_LEN;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    rearm_d = 1'b1;
                end
            end

            ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                if (bus.transmission_begin) begin
                    asm_clear     = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_HUNT;
                    frame_error_d = 1'b1;
                    error_code_d  = ERR_RESTART;
                end else if (asm_complete) begin
                    if (state_q == ST_LEN) begin
                        checksum_d = asm_byte;
                        if (asm_byte > MAX_LEN_B) begin
                            state_d      = ST_ERROR;
                            error_code_d = ERR_LEN;
                        end else if (asm_byte == 8'h00) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d     = ST_PAYLOAD;
                            remaining_d = asm_byte[4:0];
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        if (byte_valid_q && !bus.byte_ready) begin
                            state_d      = ST_ERROR;
                            error_code_d = ERR_OVF;
                        end else begin
                            checksum_d   = checksum_q ^ asm_byte;
                            byte_data_d  = asm_byte;
                            byte_valid_d = 1'b1;
                            remaining_d  = remaining_q - 5'd1;
                            if (remaining_q == 5'd1)
                                state_d = ST_CHECK;
                        end
                    end else begin
                        if (asm_byte == checksum_q)
                            state_d = ST_DONE;
                        else begin
                            state_d      = ST_ERROR;
                            error_code_d = ERR_CSUM;
                        end
                    end
                end else if (timed_out) begin
                    state_d      = ST_ERROR;
                    error_code_d = ERR_TIMEOUT;
                end

                if (state_d == ST_ERROR) begin
                    frame_error_d = 1'b1;
                    rearm_d       = 1'b1;
                end else if (state_d == ST_DONE) begin
                    frame_done_d = 1'b1;
                    rearm_d      = 1'b1;
                end
            end

            ST_DONE, ST_ERROR: begin
                asm_clear = 1'b1;
                timer_d   = '0;
                state_d   = bus.transmission_begin ? ST_HUNT : ST_IDLE;
            end

            default: begin
                asm_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            checksum_q    <= 8'h00;
            remaining_q   <= 5'd0;
            byte_data_q   <= 8'h00;
            byte_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            rearm_q       <= 1'b0;
            error_code_q  <= 3'd0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            checksum_q    <= checksum_d;
            remaining_q   <= remaining_d;
            byte_data_q   <= byte_data_d;
            byte_valid_q  <= byte_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            rearm_q       <= rearm_d;
            error_code_q  <= error_code_d;
        end
    end

    assign bus.byte_data     = byte_data_q;
    assign bus.byte_valid    = byte_valid_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.error_code    = error_code_q;
    assign bus.decoder_rearm = rearm_q;
    assign bus.busy          = (state_q != ST_IDLE);

endmodule
